// File: rtl/unidade_es.sv
// CPU-side I/O unit: switch-read IN path with button confirm, and a 4-deep OUT FIFO to the display.
// pausa, saidaValida and saidaDado are combinational decodes of registered state.
module unidade_es (
  input  logic        clock,
  input  logic        resetn,
  input  logic        lerEntrada,
  input  logic        escreverOut,
  input  logic [31:0] dadoOut,
  output logic [31:0] dadoEntrada,
  output logic        pausa,
  input  logic [15:0] chaves,
  input  logic        botao,
  output logic        saidaValida,
  output logic [31:0] saidaDado,
  input  logic        saidaPronta
);

  localparam int unsigned DataW  = 32;
  localparam int unsigned SwW    = 16;
  localparam int unsigned Depth  = 4;
  localparam int unsigned PtrW   = 2;
  localparam int unsigned CountW = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t estado;

  logic botaoS1;
  logic botaoS2;
  logic botaoAnt;
  logic confirma;

  logic [DataW-1:0]  mem [Depth];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [CountW-1:0] count;
  logic              cheio;
  logic              push;
  logic              pop;

  // Button: two-flop synchronizer, then a registered rising-edge pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      botaoS1  <= 1'b0;
      botaoS2  <= 1'b0;
      botaoAnt <= 1'b0;
      confirma <= 1'b0;
    end else begin
      botaoS1  <= botao;
      botaoS2  <= botaoS1;
      botaoAnt <= botaoS2;
      confirma <= botaoS2 & ~botaoAnt;
    end
  end

  // IN handshake: wait for a confirm press, capture the switches, release the CPU for one cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      estado      <= OCIOSO;
      dadoEntrada <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (lerEntrada) estado <= ESPERA;
        end
        ESPERA: begin
          if (confirma) begin
            estado      <= ENTREGA;
            dadoEntrada <= {{(DataW - SwW){1'b0}}, chaves};
          end
        end
        ENTREGA: estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign cheio       = (count == CountW'(Depth));
  assign saidaValida = (count != '0);
  assign saidaDado   = mem[rdPtr];
  assign push        = escreverOut & ~cheio;
  assign pop         = saidaValida & saidaPronta;

  // A full FIFO rejects the push even when a pop frees a slot in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= dadoOut;
  end

  assign pausa = (estado == ESPERA) | ((estado == OCIOSO) & lerEntrada) | (escreverOut & cheio);

endmodule

// File: tb/tb_unidade_es.sv
// Scoreboard bench for unidade_es: drivers queue expected IN/OUT words, a negedge monitor compares.
module tb_unidade_es;

  logic        clock = 1'b0;
  logic        resetn;
  logic        lerEntrada;
  logic        escreverOut;
  logic [31:0] dadoOut;
  logic [31:0] dadoEntrada;
  logic        pausa;
  logic [15:0] chaves;
  logic        botao;
  logic        saidaValida;
  logic [31:0] saidaDado;
  logic        saidaPronta;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expIn[$];
  logic [31:0] expOut[$];

  unidade_es dut (
    .clock       (clock),
    .resetn      (resetn),
    .lerEntrada  (lerEntrada),
    .escreverOut (escreverOut),
    .dadoOut     (dadoOut),
    .dadoEntrada (dadoEntrada),
    .pausa       (pausa),
    .chaves      (chaves),
    .botao       (botao),
    .saidaValida (saidaValida),
    .saidaDado   (saidaDado),
    .saidaPronta (saidaPronta)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: ENTREGA shows as lerEntrada held with pausa low; OUT pops on valid & ready.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (lerEntrada && !pausa) begin
        nChecks++;
        if (expIn.size() == 0) begin
          nFails++;
          $display("FAIL unexpectedIn: got %h, required no delivery", dadoEntrada);
        end else begin
          logic [31:0] e;
          e = expIn.pop_front();
          nChecks--;
          check("inData", dadoEntrada, e);
        end
      end
      if (saidaValida && saidaPronta) begin
        nChecks++;
        if (expOut.size() == 0) begin
          nFails++;
          $display("FAIL unexpectedOut: got %h, required no word", saidaDado);
        end else begin
          logic [31:0] e;
          e = expOut.pop_front();
          nChecks--;
          check("outData", saidaDado, e);
        end
      end
    end
  end

  // Press (or hold) the button and wait for the ENTREGA cycle; latency counted in edges.
  task automatic pressAndDeliver(input string name, input int expLat);
    int edges;
    edges = 0;
    botao = 1'b1;
    while (pausa && edges < 40) begin
      tick();
      edges++;
    end
    check({name, "Lat"}, 32'(edges), 32'(expLat));
    tick();
    lerEntrada = 1'b0;
  endtask

  task automatic pushOut(input string name, input logic [31:0] v);
    escreverOut = 1'b1;
    dadoOut     = v;
    #1;
    check(name, {31'b0, pausa}, 32'd0);
    expOut.push_back(v);
    tick();
    escreverOut = 1'b0;
  endtask

  task automatic drain(input string name);
    int edges;
    edges = 0;
    saidaPronta = 1'b1;
    while (saidaValida && edges < 40) begin
      tick();
      edges++;
    end
    check(name, {31'b0, saidaValida}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    lerEntrada  = 1'b0;
    escreverOut = 1'b0;
    dadoOut     = '0;
    chaves      = '0;
    botao       = 1'b0;
    saidaPronta = 1'b0;
    #1;
    check("rstValida", {31'b0, saidaValida}, 32'd0);
    check("rstDado", dadoEntrada, 32'd0);
    check("rstPausa", {31'b0, pausa}, 32'd0);
    lerEntrada = 1'b1;
    #1;
    check("rstPausaLer", {31'b0, pausa}, 32'd1);
    lerEntrada = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);

    // IN with switches A5C3, button after 10 cycles
    chaves     = 16'hA5C3;
    lerEntrada = 1'b1;
    #1;
    check("inPausaOcioso", {31'b0, pausa}, 32'd1);
    tick(10);
    check("inPausaEspera", {31'b0, pausa}, 32'd1);
    expIn.push_back(32'h0000_A5C3);
    pressAndDeliver("in1", 4);
    tick(3);
    check("inHold", dadoEntrada, 32'h0000_A5C3);

    // Button still held: a new IN must not complete without a fresh press
    chaves     = 16'h5A3C;
    lerEntrada = 1'b1;
    tick(8);
    check("heldNoPulse", {31'b0, pausa}, 32'd1);
    check("heldNoCapture", dadoEntrada, 32'h0000_A5C3);
    botao = 1'b0;
    tick(4);
    expIn.push_back(32'h0000_5A3C);
    pressAndDeliver("in2", 4);
    botao = 1'b0;
    tick(4);

    // Press while idle is discarded
    chaves = 16'h1234;
    botao  = 1'b1;
    tick(2);
    botao = 1'b0;
    tick(6);
    check("idlePressDiscard", dadoEntrada, 32'h0000_5A3C);
    lerEntrada = 1'b1;
    tick(8);
    check("idlePressPausa", {31'b0, pausa}, 32'd1);
    expIn.push_back(32'h0000_1234);
    pressAndDeliver("in3", 4);
    botao = 1'b0;
    tick(4);

    // Fill the FIFO with display stalled; fifth write stalls, then pop+push-reject at full
    saidaPronta = 1'b0;
    for (int i = 1; i <= 4; i++) pushOut("fillAccept", 32'(i));
    check("fullValida", {31'b0, saidaValida}, 32'd1);
    check("fullHead", saidaDado, 32'd1);
    escreverOut = 1'b1;
    dadoOut     = 32'd5;
    #1;
    check("fullPausa", {31'b0, pausa}, 32'd1);
    tick();
    check("fullPausaHeld", {31'b0, pausa}, 32'd1);
    saidaPronta = 1'b1;
    #1;
    check("fullPausaPop", {31'b0, pausa}, 32'd1);
    tick();
    check("retryPausa", {31'b0, pausa}, 32'd0);
    expOut.push_back(32'd5);
    tick();
    escreverOut = 1'b0;
    drain("drain5");

    // Idle FIFO ignores saidaPronta; then 10 back-to-back writes through a draining FIFO
    tick(3);
    check("emptyIgnore", {31'b0, saidaValida}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      pushOut("wrapPausa", 32'h100 + 32'(i));
      if (i > 0) check("wrapValida", {31'b0, saidaValida}, 32'd1);
    end
    drain("drainWrap");

    // Reset while in ESPERA with two words queued
    saidaPronta = 1'b0;
    pushOut("preRst", 32'hAAAA_0001);
    pushOut("preRst", 32'hAAAA_0002);
    lerEntrada = 1'b1;
    tick(2);
    check("preRstPausa", {31'b0, pausa}, 32'd1);
    check("preRstValida", {31'b0, saidaValida}, 32'd1);
    #2;
    resetn     = 1'b0;
    lerEntrada = 1'b0;
    #1;
    check("midRstValida", {31'b0, saidaValida}, 32'd0);
    check("midRstDado", dadoEntrada, 32'd0);
    check("midRstOcioso", {31'b0, pausa}, 32'd0);
    expOut.delete();
    tick();
    resetn = 1'b1;
    tick(2);
    check("postRstValida", {31'b0, saidaValida}, 32'd0);
    saidaPronta = 1'b1;
    pushOut("postRst", 32'hCAFE_0077);
    drain("drainPost");

    tick(3);
    check("outQueueEmpty", 32'(expOut.size()), 32'd0);
    check("inQueueEmpty", 32'(expIn.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
